// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: run/stop/single-step execution controller for the TinyRV1 core.
// Debounces the board keys, paces free-running execution with a rate divider,
// halts on a PC breakpoint and issues single-cycle clock enables in CLOCK_50.
module proc_run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TICK_DIV        = 10000000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             key_run_n,
  input  logic             key_step_n,
  input  logic             bp_en,
  input  logic [7:0]       bp_addr,
  input  logic [31:0]      pc,
  output logic             proc_ce,
  output logic             proc_rst_n,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_count,
  output logic             bp_hit
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned NKEYS  = 2;

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_BREAK = 2'd2
  } state_t;

  // Key index 0 is run/stop, index 1 is single-step.
  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] sync0_q, sync1_q;
  logic [NKEYS-1:0] level_q, level_d;
  logic [DB_W-1:0]  db_cnt_q [NKEYS];
  logic [DB_W-1:0]  db_cnt_d [NKEYS];
  logic [NKEYS-1:0] press_c;

  logic [1:0]        rst_sync_q;
  logic              run_ev_c, step_ev_c, tick_c, bp_match_c;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  state_t            state_q, state_d;
  logic              ce_d, proc_ce_q;
  logic              bp_hit_q, bp_hit_d;
  logic              skip_q, skip_d;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic              unused_pc_hi;

  assign key_raw      = {key_step_n, key_run_n};
  assign unused_pc_hi = ^pc[31:8];

  // Processor reset: asserts with rst, releases on the 2nd edge after rst rises.
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  // Two-flop synchronizers on the raw keys (idle high).
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      sync0_q <= '1;
      sync1_q <= '1;
    end else begin
      sync0_q <= key_raw;
      sync1_q <= sync0_q;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    for (int k = 0; k < int'(NKEYS); k++) begin
      level_d[k]  = level_q[k];
      db_cnt_d[k] = '0;
      press_c[k]  = 1'b0;
      if (sync1_q[k] != level_q[k]) begin
        if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_d[k] = sync1_q[k];
          press_c[k] = level_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
        end
      end
    end
  end

  // Debounced key levels and counters.
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      level_q <= '1;
      for (int k = 0; k < int'(NKEYS); k++) db_cnt_q[k] <= '0;
    end else begin
      level_q <= level_d;
      for (int k = 0; k < int'(NKEYS); k++) db_cnt_q[k] <= db_cnt_d[k];
    end
  end

  // Presses are ignored while the core is held in reset; run beats step.
  assign run_ev_c   = press_c[0] & rst_sync_q[1];
  assign step_ev_c  = press_c[1] & rst_sync_q[1] & ~press_c[0];
  assign tick_c     = (state_q == S_RUN) && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign bp_match_c = bp_en && (pc[7:0] == bp_addr) && !skip_q;

  // Next-state, enable and flag logic.
  always_comb begin
    state_d    = state_q;
    ce_d       = 1'b0;
    bp_hit_d   = bp_hit_q;
    skip_d     = skip_q;
    tick_cnt_d = '0;
    if (state_q == S_RUN && !tick_c) tick_cnt_d = tick_cnt_q + TICK_W'(1);
    if (run_ev_c) bp_hit_d = 1'b0;
    unique case (state_q)
      S_HALT: begin
        if (run_ev_c) begin
          state_d    = S_RUN;
          skip_d     = 1'b1;
          tick_cnt_d = '0;
        end else if (step_ev_c) begin
          ce_d = 1'b1;
        end
      end
      S_RUN: begin
        if (run_ev_c) begin
          state_d = S_HALT;
        end else if (tick_c) begin
          skip_d = 1'b0;
          if (bp_match_c) begin
            state_d  = S_BREAK;
            bp_hit_d = 1'b1;
          end else begin
            ce_d = 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (run_ev_c) begin
          state_d    = S_RUN;
          skip_d     = 1'b1;
          tick_cnt_d = '0;
        end else if (step_ev_c) begin
          ce_d = 1'b1;
        end
      end
      default: state_d = S_HALT;
    endcase
    step_cnt_d = step_cnt_q;
    if (ce_d && (step_cnt_q != '1)) step_cnt_d = step_cnt_q + CNT_W'(1);
  end

  // Controller state register.
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q    <= S_HALT;
      proc_ce_q  <= 1'b0;
      bp_hit_q   <= 1'b0;
      skip_q     <= 1'b1;
      tick_cnt_q <= '0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      proc_ce_q  <= ce_d & rst_sync_q[1];
      bp_hit_q   <= bp_hit_d;
      skip_q     <= skip_d;
      tick_cnt_q <= tick_cnt_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign proc_ce    = proc_ce_q;
  assign proc_rst_n = rst_sync_q[1];
  assign state      = state_q;
  assign step_count = step_cnt_q;
  assign bp_hit     = bp_hit_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl with a small PC model (+4 per proc_ce).
module tb_proc_run_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned TD = 8;
  localparam int unsigned CW = 3;

  logic          CLOCK_50 = 1'b0;
  logic          rst = 1'b0;
  logic          key_run_n = 1'b1;
  logic          key_step_n = 1'b1;
  logic          bp_en = 1'b0;
  logic [7:0]    bp_addr = 8'h00;
  logic [31:0]   pc = 32'h0;
  logic          proc_ce;
  logic          proc_rst_n;
  logic [1:0]    state;
  logic [CW-1:0] step_count;
  logic          bp_hit;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulses = 0;
  int last_ce_cyc = 0;
  int gap = 0;
  int entry_cyc = 0;
  logic [1:0] state_prev = 2'd0;

  proc_run_ctrl #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD), .CNT_W(CW)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .key_run_n  (key_run_n),
    .key_step_n (key_step_n),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .proc_ce    (proc_ce),
    .proc_rst_n (proc_rst_n),
    .state      (state),
    .step_count (step_count),
    .bp_hit     (bp_hit)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Processor model and pulse monitor, sampled mid-cycle.
  always @(negedge CLOCK_50) begin
    cyc = cyc + 1;
    if (!proc_rst_n) begin
      pc     = 32'h0;
      pulses = 0;
    end else if (proc_ce) begin
      pulses      = pulses + 1;
      gap         = cyc - last_ce_cyc;
      last_ce_cyc = cyc;
      pc          = pc + 32'd4;
    end
    if (state == 2'd1 && state_prev != 2'd1) entry_cyc = cyc;
    state_prev = state;
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge CLOCK_50);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1'b0; key_run_n = 1'b1; key_step_n = 1'b1; bp_en = 1'b0; bp_addr = 8'h00;
    tick_n(3);
    rst = 1'b1;
    tick_n(4);
  endtask

  task automatic press_run;
    key_run_n = 1'b0; tick_n(10);
    key_run_n = 1'b1; tick_n(10);
  endtask

  task automatic press_step;
    key_step_n = 1'b0; tick_n(10);
    key_step_n = 1'b1; tick_n(10);
  endtask

  task automatic test_reset;
    tick_n(3);
    tests++; if (proc_rst_n !== 1'b0) begin fails++; $display("FAIL reset_proc_rst_n: got %b expected 0", proc_rst_n); end
    tests++; if (proc_ce !== 1'b0) begin fails++; $display("FAIL reset_proc_ce: got %b expected 0", proc_ce); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
    tests++; if (step_count !== 3'd0) begin fails++; $display("FAIL reset_step_count: got %0d expected 0", step_count); end
    tests++; if (bp_hit !== 1'b0) begin fails++; $display("FAIL reset_bp_hit: got %b expected 0", bp_hit); end
    rst = 1'b1;
    @(posedge CLOCK_50); #1;
    tests++; if (proc_rst_n !== 1'b0) begin fails++; $display("FAIL reset_release_edge1: got %b expected 0", proc_rst_n); end
    @(posedge CLOCK_50); #1;
    tests++; if (proc_rst_n !== 1'b1) begin fails++; $display("FAIL reset_release_edge2: got %b expected 1", proc_rst_n); end
    tick_n(3);
  endtask

  task automatic test_bounced_step;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      key_step_n = 1'b0; tick_n(1);
      key_step_n = 1'b1; tick_n(1);
    end
    key_step_n = 1'b0; tick_n(10);
    key_step_n = 1'b1; tick_n(10);
    tests++; if (pulses != 1) begin fails++; $display("FAIL bounce_pulses: got %0d expected 1", pulses); end
    tests++; if (step_count !== 3'd1) begin fails++; $display("FAIL bounce_step_count: got %0d expected 1", step_count); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL bounce_state: got %0d expected 0", state); end
  endtask

  task automatic test_run_stop;
    int t;
    do_reset();
    press_run();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL runstop_state_run: got %0d expected 1", state); end
    t = 0;
    while (pulses < 5 && t < 100) begin tick_n(1); t++; end
    tests++; if (pulses != 5) begin fails++; $display("FAIL runstop_reach5: got %0d expected 5", pulses); end
    tests++; if (gap != int'(TD)) begin fails++; $display("FAIL runstop_gap: got %0d expected %0d", gap, TD); end
    press_run();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL runstop_state_halt: got %0d expected 0", state); end
    tests++; if (step_count !== 3'd5) begin fails++; $display("FAIL runstop_step_count: got %0d expected 5", step_count); end
    tick_n(20);
    tests++; if (pulses != 5) begin fails++; $display("FAIL runstop_no_more_ce: got %0d expected 5", pulses); end
  endtask

  task automatic test_breakpoint;
    int t;
    do_reset();
    bp_en = 1'b1; bp_addr = 8'h10;
    press_run();
    t = 0;
    while (state != 2'd2 && t < 100) begin tick_n(1); t++; end
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL bp_state_break: got %0d expected 2", state); end
    tests++; if (pulses != 4) begin fails++; $display("FAIL bp_pulses: got %0d expected 4", pulses); end
    tests++; if (pc !== 32'h10) begin fails++; $display("FAIL bp_pc: got %0h expected 10", pc); end
    tests++; if (bp_hit !== 1'b1) begin fails++; $display("FAIL bp_hit_set: got %b expected 1", bp_hit); end
    tick_n(3);
    tests++; if (pulses != 4) begin fails++; $display("FAIL bp_no_ce: got %0d expected 4", pulses); end
    press_step();
    tests++; if (pc !== 32'h14) begin fails++; $display("FAIL bp_step_pc: got %0h expected 14", pc); end
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL bp_step_state: got %0d expected 2", state); end
    press_run();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL bp_resume_state: got %0d expected 1", state); end
    tests++; if (bp_hit !== 1'b0) begin fails++; $display("FAIL bp_hit_clear: got %b expected 0", bp_hit); end
  endtask

  task automatic test_skip;
    int t;
    do_reset();
    bp_en = 1'b1; bp_addr = 8'h08;
    press_run();
    t = 0;
    while (state != 2'd2 && t < 100) begin tick_n(1); t++; end
    tests++; if (pulses != 2) begin fails++; $display("FAIL skip_break_pulses: got %0d expected 2", pulses); end
    press_run();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL skip_state: got %0d expected 1", state); end
    tests++; if (pulses != 3) begin fails++; $display("FAIL skip_pulses: got %0d expected 3", pulses); end
    tests++; if (pc !== 32'h0C) begin fails++; $display("FAIL skip_pc: got %0h expected c", pc); end
  endtask

  task automatic test_simultaneous;
    int t;
    do_reset();
    key_run_n = 1'b0; key_step_n = 1'b0;
    t = 0;
    while (state != 2'd1 && t < 20) begin tick_n(1); t++; end
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL simul_state: got %0d expected 1", state); end
    tests++; if (pulses != 0) begin fails++; $display("FAIL simul_no_step: got %0d expected 0", pulses); end
    t = 0;
    while (pulses < 1 && t < 20) begin tick_n(1); t++; end
    tests++; if (last_ce_cyc - entry_cyc != int'(TD)) begin
      fails++; $display("FAIL simul_first_tick: got %0d expected %0d", last_ce_cyc - entry_cyc, TD);
    end
    key_run_n = 1'b1; key_step_n = 1'b1;
    tick_n(10);
  endtask

  task automatic test_saturation_reset;
    int t;
    do_reset();
    press_run();
    t = 0;
    while (pulses < 9 && t < 150) begin tick_n(1); t++; end
    tests++; if (step_count !== 3'd7) begin fails++; $display("FAIL sat_step_count: got %0d expected 7", step_count); end
    tests++; if (proc_ce !== 1'b1) begin fails++; $display("FAIL sat_ce_live: got %b expected 1", proc_ce); end
    rst = 1'b0;
    #1;
    tests++; if (proc_ce !== 1'b0) begin fails++; $display("FAIL rst_mid_ce: got %b expected 0", proc_ce); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL rst_mid_state: got %0d expected 0", state); end
    tests++; if (step_count !== 3'd0) begin fails++; $display("FAIL rst_mid_step_count: got %0d expected 0", step_count); end
    tests++; if (proc_rst_n !== 1'b0) begin fails++; $display("FAIL rst_mid_proc_rst_n: got %b expected 0", proc_rst_n); end
    tick_n(3);
    rst = 1'b1;
    tick_n(4);
  endtask

  initial begin
    test_reset();
    test_bounced_step();
    test_run_stop();
    test_breakpoint();
    test_skip();
    test_simultaneous();
    test_saturation_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
